// File: rtl/regbank_arbiter.sv
// -----------------------------------------------------------------------------
// regbank_arbiter
//
// Two-port arbiter that owns the configuration register bank. Port A is the
// SPI slave side and port B is an on-chip requester (self-test, sequencer).
// Accesses are serialised with round-robin fairness. Each access takes one
// IDLE cycle, where the request is sampled and latched, and one ACCESS cycle,
// where the grant pulses and read data and error are driven.
//
// Optional feature: define REGBANK_ARB_LOCK_EN to add the a_lock/b_lock ports.
// A granted access with lock=1 gives that port exclusive ownership. Ownership
// ends on that port's next granted access with lock=0.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   a_req/b_req           access request, held until the grant
//   a_we/b_we             1 = write, 0 = read
//   a_addr/b_addr         MSB 0 = config bank, MSB 1 = status bank, low bits index
//   a_wdata/b_wdata       write data
//   a_lock/b_lock         lock request (REGBANK_ARB_LOCK_EN only)
//   a_gnt/b_gnt           one-cycle pulse completing the access
//   a_rdata/b_rdata       read data, valid with the grant (0 otherwise)
//   a_err/b_err           access error, valid with the grant (0 otherwise)
//   status_regs           external status bank, register i at [i*REG_WIDTH +: REG_WIDTH]
//   config_regs           config bank, same packing
// -----------------------------------------------------------------------------
module regbank_arbiter #(
    parameter int NUM_REGS   = 8,
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          a_req,
    input  logic                          a_we,
    input  logic [ADDR_WIDTH-1:0]         a_addr,
    input  logic [REG_WIDTH-1:0]          a_wdata,
`ifdef REGBANK_ARB_LOCK_EN
    input  logic                          a_lock,
`endif
    output logic                          a_gnt,
    output logic [REG_WIDTH-1:0]          a_rdata,
    output logic                          a_err,
    input  logic                          b_req,
    input  logic                          b_we,
    input  logic [ADDR_WIDTH-1:0]         b_addr,
    input  logic [REG_WIDTH-1:0]          b_wdata,
`ifdef REGBANK_ARB_LOCK_EN
    input  logic                          b_lock,
`endif
    output logic                          b_gnt,
    output logic [REG_WIDTH-1:0]          b_rdata,
    output logic                          b_err,
    input  logic [NUM_REGS*REG_WIDTH-1:0] status_regs,
    output logic [NUM_REGS*REG_WIDTH-1:0] config_regs
);

    localparam int   IDXW   = ADDR_WIDTH - 1;
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                                r_state;
    state_t                                w_state_nxt;
    logic                                  r_last;
    logic                                  r_sel;
    logic                                  w_sel_nxt;
    logic                                  w_load;
    logic                                  r_we;
    logic [ADDR_WIDTH-1:0]                 r_addr;
    logic [REG_WIDTH-1:0]                  r_wdata;
    logic [NUM_REGS-1:0][REG_WIDTH-1:0]    r_cfg;
    logic [NUM_REGS-1:0][REG_WIDTH-1:0]    w_status;
    logic                                  w_a_elig;
    logic                                  w_b_elig;
    logic [IDXW-1:0]                       w_idx;
    logic                                  w_is_status;
    logic                                  w_idx_ok;
    logic                                  w_active;
    logic                                  w_err;
    logic                                  w_do_write;
    logic [REG_WIDTH-1:0]                  w_rdata;

`ifdef REGBANK_ARB_LOCK_EN
    logic                                  r_lock;
    logic                                  r_own_a;
    logic                                  r_own_b;
`endif

    assign w_status    = status_regs;
    assign config_regs = r_cfg;

    // A port is eligible when requesting and the other port does not own the bank.
    always_comb begin
        w_a_elig = a_req;
        w_b_elig = b_req;
`ifdef REGBANK_ARB_LOCK_EN
        w_a_elig = a_req && !r_own_b;
        w_b_elig = b_req && !r_own_a;
`endif
    end

    // Next-state and winner selection
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_a_elig && w_b_elig) begin
                    // On a tie, the port that did not win last time goes first.
                    w_sel_nxt   = (r_last == PORT_B) ? PORT_A : PORT_B;
                    w_load      = 1'b1;
                    w_state_nxt = ACCESS;
                end else if (w_a_elig) begin
                    w_sel_nxt   = PORT_A;
                    w_load      = 1'b1;
                    w_state_nxt = ACCESS;
                end else if (w_b_elig) begin
                    w_sel_nxt   = PORT_B;
                    w_load      = 1'b1;
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Access decode. This logic depends only on latched fields, so there is no
    // path from req to the outputs. A reset during ACCESS masks the grant and
    // suppresses the write.
    always_comb begin
        w_idx       = r_addr[IDXW-1:0];
        w_is_status = r_addr[ADDR_WIDTH-1];
        w_idx_ok    = (32'(w_idx) < NUM_REGS);
        w_active    = (r_state == ACCESS) && !rst;
        w_err       = !w_idx_ok || (w_is_status && r_we);
        w_do_write  = w_active && r_we && !w_is_status && w_idx_ok;
        w_rdata     = '0;
        if (w_idx_ok) begin
            w_rdata = w_is_status ? w_status[w_idx] : r_cfg[w_idx];
        end
    end

    always_comb begin
        a_gnt   = w_active && (r_sel == PORT_A);
        b_gnt   = w_active && (r_sel == PORT_B);
        a_rdata = a_gnt ? w_rdata : '0;
        b_rdata = b_gnt ? w_rdata : '0;
        a_err   = a_gnt && w_err;
        b_err   = b_gnt && w_err;
    end

    // Control state and the config bank
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= PORT_B;
            r_cfg   <= '0;
`ifdef REGBANK_ARB_LOCK_EN
            r_own_a <= 1'b0;
            r_own_b <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ACCESS) begin
                r_last <= r_sel;
`ifdef REGBANK_ARB_LOCK_EN
                // A granted access sets or clears its own port's ownership.
                if (r_sel == PORT_A) begin
                    r_own_a <= r_lock;
                end else begin
                    r_own_b <= r_lock;
                end
`endif
            end
            if (w_do_write) begin
                r_cfg[w_idx] <= r_wdata;
            end
        end
    end

    // Request fields are latched in IDLE only. A request dropped during
    // ACCESS is still completed.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_sel   <= w_sel_nxt;
            r_we    <= (w_sel_nxt == PORT_A) ? a_we    : b_we;
            r_addr  <= (w_sel_nxt == PORT_A) ? a_addr  : b_addr;
            r_wdata <= (w_sel_nxt == PORT_A) ? a_wdata : b_wdata;
`ifdef REGBANK_ARB_LOCK_EN
            r_lock  <= (w_sel_nxt == PORT_A) ? a_lock  : b_lock;
`endif
        end
    end

endmodule

// File: tb/tb_regbank_arbiter.sv
module tb_regbank_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [3:0]  a_addr, b_addr;
    logic [7:0]  a_wdata, b_wdata;
    logic        a_gnt, a_err, b_gnt, b_err;
    logic [7:0]  a_rdata, b_rdata;
    logic [63:0] status_regs;
    logic [63:0] config_regs;
`ifdef REGBANK_ARB_LOCK_EN
    logic        a_lock, b_lock;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regbank_arbiter #(.NUM_REGS(8), .REG_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
`ifdef REGBANK_ARB_LOCK_EN
        .a_lock(a_lock),
`endif
        .a_gnt(a_gnt), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
`ifdef REGBANK_ARB_LOCK_EN
        .b_lock(b_lock),
`endif
        .b_gnt(b_gnt), .b_rdata(b_rdata), .b_err(b_err),
        .status_regs(status_regs), .config_regs(config_regs)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock, then settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
`ifdef REGBANK_ARB_LOCK_EN
        a_lock = 0; b_lock = 0;
`endif
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        status_regs = 64'h0;
        idle_inputs();
        do_reset();

        // Reset, then idle
        chk("rst_cfg", config_regs, 64'h0);
        chk("rst_gnt", {a_gnt, b_gnt}, 2'b00);
        chk("rst_rdata", {a_rdata, b_rdata}, 16'h0);
        chk("rst_err", {a_err, b_err}, 2'b00);
        tick();
        chk("idle_gnt", {a_gnt, b_gnt}, 2'b00);

        // A writes 0x5A to config register 2
        a_req = 1; a_we = 1; a_addr = 4'h2; a_wdata = 8'h5A;
        tick();
        chk("wr_a_gnt", {a_gnt, b_gnt}, 2'b10);
        chk("wr_a_err", a_err, 1'b0);
        chk("wr_cfg_n1", config_regs, 64'h0);
        a_req = 0;
        tick();
        chk("wr_cfg_n2", config_regs[23:16], 8'h5A);
        chk("wr_gnt_off", a_gnt, 1'b0);

        // B reads register 2
        b_req = 1; b_we = 0; b_addr = 4'h2;
        tick();
        chk("rd_b_gnt", {a_gnt, b_gnt}, 2'b01);
        chk("rd_b_rdata", b_rdata, 8'h5A);
        chk("rd_b_err", b_err, 1'b0);
        chk("rd_a_rdata0", a_rdata, 8'h0);
        b_req = 0;
        tick();

        // A overwrites register 2: the grant cycle shows the old value.
        a_req = 1; a_we = 1; a_addr = 4'h2; a_wdata = 8'h33;
        tick();
        chk("prewr_rdata", a_rdata, 8'h5A);
        a_req = 0;
        tick();
        chk("prewr_cfg", config_regs, 64'h0000_0000_0033_0000);

        // Contention from reset: A, B, A, B at cycles 1, 3, 5, 7
        rst = 1;
        tick();
        rst = 0;
        a_req = 1; a_we = 0; a_addr = 4'h1;
        b_req = 1; b_we = 0; b_addr = 4'h0;
        for (int k = 1; k <= 8; k++) begin
            logic [1:0] exp_g;
            tick();
            exp_g = (k == 1 || k == 5) ? 2'b10 : ((k == 3 || k == 7) ? 2'b01 : 2'b00);
            chk($sformatf("rr_c%0d", k), {a_gnt, b_gnt}, exp_g);
        end
        idle_inputs();
        tick();

        // Config write to register 4, then a status write to 0xC
        status_regs = 64'h0;
        status_regs[39:32] = 8'hC4;
        a_req = 1; a_we = 1; a_addr = 4'h4; a_wdata = 8'h11;
        tick();
        a_req = 0;
        tick();
        chk("cfg4_wr", config_regs, 64'h0000_0011_0000_0000);
        a_req = 1; a_we = 1; a_addr = 4'hC; a_wdata = 8'hFF;
        tick();
        chk("st_wr_gnt", a_gnt, 1'b1);
        chk("st_wr_err", a_err, 1'b1);
        a_req = 0;
        tick();
        tick();
        chk("st_wr_nochg", config_regs, 64'h0000_0011_0000_0000);
        a_req = 1; a_we = 0; a_addr = 4'hC;
        tick();
        chk("st_rd_rdata", a_rdata, 8'hC4);
        chk("st_rd_err", a_err, 1'b0);
        a_req = 0;
        tick();

        // B reads config register 4, which shares its index with status register 4.
        b_req = 1; b_we = 0; b_addr = 4'h4;
        tick();
        chk("cfg4_rd_b", b_rdata, 8'h11);
        b_req = 0;
        tick();

        // Write requested in the same cycle that reset is asserted
        rst = 1;
        a_req = 1; a_we = 1; a_addr = 4'h3; a_wdata = 8'h77;
        tick();
        chk("rstwr_gnt", {a_gnt, b_gnt}, 2'b00);
        rst = 0; a_req = 0;
        tick();
        chk("rstwr_gnt2", {a_gnt, b_gnt}, 2'b00);
        chk("rstwr_cfg", config_regs, 64'h0);

        // Reset asserted during the ACCESS cycle aborts the write.
        a_req = 1; a_we = 1; a_addr = 4'h3; a_wdata = 8'h66;
        tick();
        rst = 1; a_req = 0;
        #1;
        chk("rstacc_gnt", a_gnt, 1'b0);
        tick();
        rst = 0;
        tick();
        tick();
        chk("rstacc_cfg", config_regs, 64'h0);

`ifdef REGBANK_ARB_LOCK_EN
        // A locks with a read, B waits until A's unlocking write completes.
        do_reset();
        a_req = 1; a_we = 0; a_addr = 4'h1; a_lock = 1;
        b_req = 1; b_we = 0; b_addr = 4'h2; b_lock = 0;
        tick();
        chk("lk_c1", {a_gnt, b_gnt}, 2'b10);
        a_we = 1; a_wdata = 8'hA5; a_lock = 0;
        tick();
        chk("lk_c2", {a_gnt, b_gnt}, 2'b00);
        tick();
        chk("lk_c3", {a_gnt, b_gnt}, 2'b10);
        a_req = 0;
        tick();
        chk("lk_c4", {a_gnt, b_gnt}, 2'b00);
        tick();
        chk("lk_c5", {a_gnt, b_gnt}, 2'b01);
        chk("lk_cfg", config_regs[15:8], 8'hA5);
        idle_inputs();
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
